dmem_arbiter: RTL and testbench
===============================

# dmem_arbiter

Two-port arbiter and access sequencer for the shared 64 x 64-bit data memory. Accepts load/store requests from two requesters (port 0: CPU load/store unit, port 1: DMA/test loader), grants one at a time (round-robin or fixed priority), and drives the memory's MemoryRead/MemoryWrite/Address/WriteData for a fixed number of cycles. Returns read data with a one-cycle Done pulse. Sits between the requesters and the data memory; it is the memory's only master.

## Interface
- ADDR_W, 64, address width
- DATA_W, 64, data width
- MEM_LATENCY, 2, cycles memory strobes are held before ReadData is sampled (>= 1)
- FIXED_PRIORITY, 0, 1 = port 0 always wins; 0 = round-robin

- Clock  in  1  single clock, rising-edge
- ResetN  in  1  asynchronous, active-low reset
- Req0 / Req1  in  1  request, held until Done
- Write0 / Write1  in  1  1 = store, 0 = load; stable while Req high
- Addr0 / Addr1  in  ADDR_W  doubleword index
- WData0 / WData1  in  DATA_W  store data
- Done0 / Done1  out  1  one-cycle completion pulse
- RData0 / RData1  out  DATA_W  load result, valid with Done, held until next load completion on that port
- MemAddress  out  ADDR_W  to memory Address
- MemWriteData  out  DATA_W  to memory WriteData
- MemoryRead / MemoryWrite  out  1  memory strobes
- MemReadData  in  DATA_W  from memory ReadData
- Busy  out  1  high in ACCESS and RESPOND

## Operation
- FSM states: IDLE, ACCESS, RESPOND. All outputs registered.
- IDLE: when Req0 or Req1 is high at a rising edge, the block picks a winner, latches its Write/Addr/WData, loads the counter with MEM_LATENCY-1 and goes to ACCESS. If neither request is high, it stays in IDLE.
- Arbitration:
  - FIXED_PRIORITY=1: port 0 wins whenever Req0 is high.
  - Round-robin: if both ports request, the port not granted last wins. A single requester always wins.
  - The last-grant pointer updates on entry to RESPOND.
- ACCESS: MemAddress/MemWriteData drive the latched values. MemoryWrite is driven if the request is a store, MemoryRead if it is a load; never both. The counter decrements each cycle. At count 0 the block goes to RESPOND and, for a load, captures MemReadData into the granted port's RData.
- RESPOND: both strobes are low. Done of the granted port is high for exactly one cycle. Next state is IDLE.
- Each requester sees only its own transactions. RData of the other port is unchanged.
- Stores do not alter RData.
- Address is passed through unchecked. Range is the memory's concern.

## Timing
- Reset (ResetN low, asynchronous):
  - state IDLE, last-grant = 1 (port 0 wins first tie), counter 0;
  - all outputs 0: Done0/1, RData0/1, MemAddress, MemWriteData, strobes, Busy.
- Latency:
  - request sampled at edge k;
  - strobes high from edge k+1 through edge k+MEM_LATENCY;
  - Done high from edge k+MEM_LATENCY+1 for one cycle.
- Throughput: one transaction per MEM_LATENCY+2 cycles. A port holding Req high after Done is re-arbitrated in the following IDLE cycle.
- Boundary conditions:
  - Req dropped mid-transaction: ignored. The transaction completes and Done still pulses.
  - Requester input changes during ACCESS: no effect, because values are latched.
  - Both ports request in the same cycle: resolved by the arbitration policy. The losing port waits with Req high, and no request is lost.
  - Reset mid-ACCESS: strobes deassert immediately and the transaction is dropped. No Done is issued, and an in-flight store may or may not have reached memory.
- MemoryRead and MemoryWrite are never high in the same cycle, including through reset.

## Test plan
- Reset: ResetN low mid-ACCESS → all outputs 0 asynchronously, no Done after release; FSM returns to IDLE.
- Single load (MEM_LATENCY=2): memory preloaded Memory[i]=i, Req0 load Addr0=5 → MemoryRead high for 2 cycles, Done0 at 3rd edge after sampling, RData0=5, RData1 unchanged.
- Store then load: Req1 store Addr1=10 WData1=0xDEAD → MemoryWrite high 2 cycles, Done1, RData1 unchanged; then Req1 load Addr1=10 → RData1=0xDEAD.
- Round-robin contention: both ports hold Req (loads, addresses 3 and 7) for 4 transactions → grants 0,1,0,1; RData0=3, RData1=7; spacing MEM_LATENCY+2 cycles.
- Fixed priority (FIXED_PRIORITY=1): both held high → port 0 granted every time until Req0 drops, then port 1 granted next IDLE.
- Req dropped after sampling plus input change during ACCESS → original address accessed, Done pulses once; strobe mutual exclusion asserted throughout.

Source files
------------

// File: rtl/dmem_arbiter_if.sv
// Bundle of the two requester ports and the data-memory bus around dmem_arbiter.
// The master side is the requesters plus the memory; the slave side is the arbiter.
interface dmem_arbiter_if #(
  parameter int ADDR_W = 64,
  parameter int DATA_W = 64
);
  logic              Req0;
  logic              Req1;
  logic              Write0;
  logic              Write1;
  logic [ADDR_W-1:0] Addr0;
  logic [ADDR_W-1:0] Addr1;
  logic [DATA_W-1:0] WData0;
  logic [DATA_W-1:0] WData1;
  logic              Done0;
  logic              Done1;
  logic [DATA_W-1:0] RData0;
  logic [DATA_W-1:0] RData1;
  logic [ADDR_W-1:0] MemAddress;
  logic [DATA_W-1:0] MemWriteData;
  logic              MemoryRead;
  logic              MemoryWrite;
  logic [DATA_W-1:0] MemReadData;
  logic              Busy;

  modport master (
    output Req0, Req1, Write0, Write1, Addr0, Addr1, WData0, WData1, MemReadData,
    input  Done0, Done1, RData0, RData1, MemAddress, MemWriteData,
           MemoryRead, MemoryWrite, Busy
  );

  modport slave (
    input  Req0, Req1, Write0, Write1, Addr0, Addr1, WData0, WData1, MemReadData,
    output Done0, Done1, RData0, RData1, MemAddress, MemWriteData,
           MemoryRead, MemoryWrite, Busy
  );
endinterface

// File: rtl/dmem_arbiter.sv
// Two-port arbiter and access sequencer for the shared data memory: grants one
// load/store at a time, holds the memory strobes for MEM_LATENCY cycles, then pulses Done.
module dmem_arbiter #(
  parameter int ADDR_W         = 64,
  parameter int DATA_W         = 64,
  parameter int MEM_LATENCY    = 2,
  parameter int FIXED_PRIORITY = 0
) (
  input  logic          Clock,
  input  logic          ResetN,
  dmem_arbiter_if.slave bus
);

  localparam int CNT_W = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MEM_LATENCY - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACCESS  = 2'd1,
    RESPOND = 2'd2
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic [CNT_W-1:0]  cnt;
  logic [CNT_W-1:0]  cnt_nxt;
  logic              gnt;
  logic              gnt_nxt;
  logic              last_gnt;
  logic              last_nxt;
  logic              grab;

  logic              wr_p0;
  logic [ADDR_W-1:0] addr_p0;
  logic [DATA_W-1:0] wdata_p0;

  logic              done0_p1;
  logic              done1_p1;
  logic              mem_rd_p1;
  logic              mem_wr_p1;
  logic              busy_p1;
  logic [ADDR_W-1:0] mem_addr_p1;
  logic [DATA_W-1:0] mem_wdata_p1;
  logic [DATA_W-1:0] rdata0_p1;
  logic [DATA_W-1:0] rdata1_p1;

  // Returns the winning port (0 or 1); only meaningful when at least one request is high.
  function automatic logic pick_port(input logic r0, input logic r1, input logic last);
    if (r0 && r1) begin
      return (FIXED_PRIORITY != 0) ? 1'b0 : ~last;
    end
    return ~r0;
  endfunction

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    gnt_nxt   = gnt;
    last_nxt  = last_gnt;
    grab      = 1'b0;
    case (state)
      IDLE: begin
        if (bus.Req0 || bus.Req1) begin
          grab      = 1'b1;
          gnt_nxt   = pick_port(bus.Req0, bus.Req1, last_gnt);
          cnt_nxt   = CNT_LOAD;
          state_nxt = ACCESS;
        end
      end
      ACCESS: begin
        if (cnt == '0) begin
          state_nxt = RESPOND;
          last_nxt  = gnt;
        end else begin
          cnt_nxt = cnt - 1'b1;
        end
      end
      RESPOND: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge Clock or negedge ResetN) begin
    if (!ResetN) begin
      state    <= IDLE;
      cnt      <= '0;
      gnt      <= 1'b0;
      last_gnt <= 1'b1;
    end else begin
      state    <= state_nxt;
      cnt      <= cnt_nxt;
      gnt      <= gnt_nxt;
      last_gnt <= last_nxt;
    end
  end

  // Grant stage: the winner's request is frozen here so requester changes during ACCESS are ignored.
  always_ff @(posedge Clock or negedge ResetN) begin
    if (!ResetN) begin
      wr_p0    <= 1'b0;
      addr_p0  <= '0;
      wdata_p0 <= '0;
    end else if (grab) begin
      wr_p0    <= gnt_nxt ? bus.Write1 : bus.Write0;
      addr_p0  <= gnt_nxt ? bus.Addr1  : bus.Addr0;
      wdata_p0 <= gnt_nxt ? bus.WData1 : bus.WData0;
    end
  end

  // Output stage: decoded from the current state, so strobes trail ACCESS by one cycle
  // and read data is sampled in RESPOND after the strobes have been held MEM_LATENCY cycles.
  always_ff @(posedge Clock or negedge ResetN) begin
    if (!ResetN) begin
      done0_p1     <= 1'b0;
      done1_p1     <= 1'b0;
      mem_rd_p1    <= 1'b0;
      mem_wr_p1    <= 1'b0;
      busy_p1      <= 1'b0;
      mem_addr_p1  <= '0;
      mem_wdata_p1 <= '0;
      rdata0_p1    <= '0;
      rdata1_p1    <= '0;
    end else begin
      mem_rd_p1    <= (state == ACCESS) && !wr_p0;
      mem_wr_p1    <= (state == ACCESS) &&  wr_p0;
      mem_addr_p1  <= addr_p0;
      mem_wdata_p1 <= wdata_p0;
      done0_p1     <= (state == RESPOND) && !gnt;
      done1_p1     <= (state == RESPOND) &&  gnt;
      busy_p1      <= (state_nxt != IDLE);
      if ((state == RESPOND) && !wr_p0) begin
        if (gnt) begin
          rdata1_p1 <= bus.MemReadData;
        end else begin
          rdata0_p1 <= bus.MemReadData;
        end
      end
    end
  end

  assign bus.Done0        = done0_p1;
  assign bus.Done1        = done1_p1;
  assign bus.RData0       = rdata0_p1;
  assign bus.RData1       = rdata1_p1;
  assign bus.MemAddress   = mem_addr_p1;
  assign bus.MemWriteData = mem_wdata_p1;
  assign bus.MemoryRead   = mem_rd_p1;
  assign bus.MemoryWrite  = mem_wr_p1;
  assign bus.Busy         = busy_p1;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Scoreboard bench for dmem_arbiter: a round-robin instance and a fixed-priority
// instance, each with its own 64-word memory preloaded with Memory[i] = i.
module tb_dmem_arbiter;
  localparam int ML = 2;

  logic clk      = 1'b0;
  logic rst_n    = 1'b1;
  logic mem_init = 1'b1;
  always #5 clk = ~clk;

  dmem_arbiter_if #(.ADDR_W(64), .DATA_W(64)) ifa ();
  dmem_arbiter_if #(.ADDR_W(64), .DATA_W(64)) ifb ();

  dmem_arbiter #(.ADDR_W(64), .DATA_W(64), .MEM_LATENCY(ML), .FIXED_PRIORITY(0)) dut_rr (
    .Clock(clk), .ResetN(rst_n), .bus(ifa)
  );
  dmem_arbiter #(.ADDR_W(64), .DATA_W(64), .MEM_LATENCY(ML), .FIXED_PRIORITY(1)) dut_fp (
    .Clock(clk), .ResetN(rst_n), .bus(ifb)
  );

  // Requester drive arrays, indexed [dut][port]; dut 0 = round-robin, dut 1 = fixed priority
  logic        rq [2][2];
  logic        wr [2][2];
  logic [63:0] ad [2][2];
  logic [63:0] wd [2][2];
  logic        dn [2][2];

  assign ifa.Req0 = rq[0][0];  assign ifa.Req1 = rq[0][1];
  assign ifa.Write0 = wr[0][0];  assign ifa.Write1 = wr[0][1];
  assign ifa.Addr0 = ad[0][0];  assign ifa.Addr1 = ad[0][1];
  assign ifa.WData0 = wd[0][0];  assign ifa.WData1 = wd[0][1];
  assign ifb.Req0 = rq[1][0];  assign ifb.Req1 = rq[1][1];
  assign ifb.Write0 = wr[1][0];  assign ifb.Write1 = wr[1][1];
  assign ifb.Addr0 = ad[1][0];  assign ifb.Addr1 = ad[1][1];
  assign ifb.WData0 = wd[1][0];  assign ifb.WData1 = wd[1][1];
  assign dn[0][0] = ifa.Done0;  assign dn[0][1] = ifa.Done1;
  assign dn[1][0] = ifb.Done0;  assign dn[1][1] = ifb.Done1;

  logic [63:0] mem_a [64];
  logic [63:0] mem_b [64];
  assign ifa.MemReadData = mem_a[ifa.MemAddress[5:0]];
  assign ifb.MemReadData = mem_b[ifb.MemAddress[5:0]];

  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < 64; i++) begin
        mem_a[i] <= 64'(i);
        mem_b[i] <= 64'(i);
      end
    end else begin
      if (ifa.MemoryWrite) mem_a[ifa.MemAddress[5:0]] <= ifa.MemWriteData;
      if (ifb.MemoryWrite) mem_b[ifb.MemAddress[5:0]] <= ifb.MemWriteData;
    end
  end

  typedef struct {
    int          port;
    logic        wr;
    logic [63:0] addr;
    logic [63:0] wdata;
    logic [63:0] rdata;
    logic        gap;
  } txn_t;

  txn_t        sbq [2][$];
  logic [63:0] exp_rd [2][2];
  int          scnt [2];
  int          last_done [2];
  int          cyc;
  int          n_chk  = 0;
  int          n_pass = 0;
  int          n_fail = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) begin
      n_pass++;
    end else begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", nm, act, exp);
    end
  endtask

  task automatic mon(input int d, input logic dn0, input logic dn1, input logic mr, input logic mw,
                     input logic [63:0] rd0, input logic [63:0] rd1,
                     input logic [63:0] ma, input logic [63:0] mwd);
    txn_t e;
    int   p;
    if (!rst_n) begin
      sbq[d].delete();
      scnt[d] = 0;
      exp_rd[d][0] = '0;
      exp_rd[d][1] = '0;
      return;
    end
    if (mr || mw) begin
      chk("strobe_expected", 64'(sbq[d].size() != 0), 64'd1);
      if (sbq[d].size() != 0) begin
        e = sbq[d][0];
        chk("mem_address", ma, e.addr);
        chk("strobe_kind", {62'b0, mr, mw}, {62'b0, !e.wr, e.wr});
        if (e.wr) chk("mem_wdata", mwd, e.wdata);
        scnt[d]++;
      end
    end
    if (dn0 || dn1) begin
      chk("done_excl", 64'(dn0 & dn1), 64'd0);
      chk("done_expected", 64'(sbq[d].size() != 0), 64'd1);
      if (sbq[d].size() != 0) begin
        e = sbq[d].pop_front();
        p = dn1 ? 1 : 0;
        chk("grant_port", 64'(p), 64'(e.port));
        chk("strobe_cycles", 64'(scnt[d]), 64'(ML));
        if (!e.wr) exp_rd[d][e.port] = e.rdata;
        chk("rdata0", rd0, exp_rd[d][0]);
        chk("rdata1", rd1, exp_rd[d][1]);
        if (e.gap) chk("done_spacing", 64'(cyc - last_done[d]), 64'(ML + 2));
      end
      scnt[d] = 0;
      last_done[d] = cyc;
    end
  endtask

  initial begin
    cyc = 0;
    for (int d = 0; d < 2; d++) begin
      scnt[d] = 0;
      last_done[d] = 0;
      exp_rd[d][0] = '0;
      exp_rd[d][1] = '0;
    end
    forever begin
      @(negedge clk);
      cyc++;
      mon(0, ifa.Done0, ifa.Done1, ifa.MemoryRead, ifa.MemoryWrite,
          ifa.RData0, ifa.RData1, ifa.MemAddress, ifa.MemWriteData);
      mon(1, ifb.Done0, ifb.Done1, ifb.MemoryRead, ifb.MemoryWrite,
          ifb.RData0, ifb.RData1, ifb.MemAddress, ifb.MemWriteData);
    end
  end

  task automatic set_req(input int d, input int p, input logic w, input logic [63:0] a,
                         input logic [63:0] v);
    wr[d][p] = w;
    ad[d][p] = a;
    wd[d][p] = v;
  endtask

  task automatic push(input int d, input int p, input logic w, input logic [63:0] a,
                      input logic [63:0] v, input logic [63:0] r, input logic g);
    txn_t e;
    e.port = p; e.wr = w; e.addr = a; e.wdata = v; e.rdata = r; e.gap = g;
    sbq[d].push_back(e);
  endtask

  // One isolated transaction, started at a negedge while the DUT is idle
  task automatic run1(input int d, input int p, input logic w, input logic [63:0] a,
                      input logic [63:0] v, input logic [63:0] r, input string nm);
    int   n;
    logic got;
    set_req(d, p, w, a, v);
    push(d, p, w, a, v, r, 1'b0);
    rq[d][p] = 1'b1;
    got = 1'b0;
    n = 0;
    while (!got && n < 20) begin
      @(negedge clk);
      n++;
      got = dn[d][p];
    end
    rq[d][p] = 1'b0;
    chk({nm, "_done"}, 64'(got), 64'd1);
    chk({nm, "_latency"}, 64'(n), 64'(ML + 2));
  endtask

  task automatic rst_chk(input string nm, input logic [4:0] ctl, input logic [63:0] r0,
                         input logic [63:0] r1, input logic [63:0] ma, input logic [63:0] mwd);
    chk({nm, "_ctl"}, {59'b0, ctl}, 64'd0);
    chk({nm, "_rdata0"}, r0, 64'd0);
    chk({nm, "_rdata1"}, r1, 64'd0);
    chk({nm, "_maddr"}, ma, 64'd0);
    chk({nm, "_mwdata"}, mwd, 64'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int   n;
    int   nd;
    logic got;
    for (int d = 0; d < 2; d++) begin
      for (int p = 0; p < 2; p++) begin
        rq[d][p] = 1'b0;
        set_req(d, p, 1'b0, 64'd0, 64'd0);
      end
    end
    #1 rst_n = 1'b0;
    #2;
    rst_chk("reset_a", {ifa.Done0, ifa.Done1, ifa.MemoryRead, ifa.MemoryWrite, ifa.Busy},
            ifa.RData0, ifa.RData1, ifa.MemAddress, ifa.MemWriteData);
    rst_chk("reset_b", {ifb.Done0, ifb.Done1, ifb.MemoryRead, ifb.MemoryWrite, ifb.Busy},
            ifb.RData0, ifb.RData1, ifb.MemAddress, ifb.MemWriteData);
    repeat (2) @(posedge clk);
    #1 mem_init = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    run1(0, 0, 1'b0, 64'd5, 64'd0, 64'd5, "load5");
    run1(0, 1, 1'b1, 64'd10, 64'hDEAD, 64'd0, "store10");
    run1(0, 1, 1'b0, 64'd10, 64'd0, 64'hDEAD, "load10");

    // Round-robin contention: both ports hold loads for four grants, 0,1,0,1
    set_req(0, 0, 1'b0, 64'd3, 64'd0);
    set_req(0, 1, 1'b0, 64'd7, 64'd0);
    push(0, 0, 1'b0, 64'd3, 64'd0, 64'd3, 1'b0);
    push(0, 1, 1'b0, 64'd7, 64'd0, 64'd7, 1'b1);
    push(0, 0, 1'b0, 64'd3, 64'd0, 64'd3, 1'b1);
    push(0, 1, 1'b0, 64'd7, 64'd0, 64'd7, 1'b1);
    rq[0][0] = 1'b1;
    rq[0][1] = 1'b1;
    nd = 0;
    n = 0;
    while (nd < 4 && n < 40) begin
      @(negedge clk);
      n++;
      if (dn[0][0] || dn[0][1]) nd++;
    end
    rq[0][0] = 1'b0;
    rq[0][1] = 1'b0;
    chk("rr_done_count", 64'(nd), 64'd4);

    // Request dropped right after sampling, inputs changed during ACCESS
    set_req(0, 0, 1'b0, 64'd20, 64'd0);
    push(0, 0, 1'b0, 64'd20, 64'd0, 64'd20, 1'b0);
    rq[0][0] = 1'b1;
    @(posedge clk);
    #1;
    rq[0][0] = 1'b0;
    set_req(0, 0, 1'b1, 64'd33, 64'h1234);
    got = 1'b0;
    n = 0;
    while (!got && n < 20) begin
      @(negedge clk);
      n++;
      got = dn[0][0];
    end
    chk("drop_done", 64'(got), 64'd1);
    nd = 0;
    repeat (10) begin
      @(negedge clk);
      if (dn[0][0] || dn[0][1]) nd++;
    end
    chk("drop_no_extra_done", 64'(nd), 64'd0);
    set_req(0, 0, 1'b0, 64'd0, 64'd0);

    // Fixed priority: port 0 wins while held, port 1 gets the next idle slot after it drops
    set_req(1, 0, 1'b0, 64'd4, 64'd0);
    set_req(1, 1, 1'b0, 64'd6, 64'd0);
    push(1, 0, 1'b0, 64'd4, 64'd0, 64'd4, 1'b0);
    push(1, 0, 1'b0, 64'd4, 64'd0, 64'd4, 1'b1);
    push(1, 0, 1'b0, 64'd4, 64'd0, 64'd4, 1'b1);
    push(1, 1, 1'b0, 64'd6, 64'd0, 64'd6, 1'b1);
    rq[1][0] = 1'b1;
    rq[1][1] = 1'b1;
    nd = 0;
    n = 0;
    while (nd < 4 && n < 60) begin
      @(negedge clk);
      n++;
      if (dn[1][0] || dn[1][1]) begin
        nd++;
        if (nd == 3) rq[1][0] = 1'b0;
      end
    end
    rq[1][0] = 1'b0;
    rq[1][1] = 1'b0;
    chk("fp_done_count", 64'(nd), 64'd4);

    // Reset while the read strobe is active: everything clears at once, no Done follows
    set_req(0, 0, 1'b0, 64'd9, 64'd0);
    push(0, 0, 1'b0, 64'd9, 64'd0, 64'd9, 1'b0);
    rq[0][0] = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("pre_reset_strobe", 64'(ifa.MemoryRead), 64'd1);
    #1;
    rst_n = 1'b0;
    rq[0][0] = 1'b0;
    #1;
    rst_chk("reset_mid", {ifa.Done0, ifa.Done1, ifa.MemoryRead, ifa.MemoryWrite, ifa.Busy},
            ifa.RData0, ifa.RData1, ifa.MemAddress, ifa.MemWriteData);
    @(negedge clk);
    @(negedge clk);
    #2 rst_n = 1'b1;
    nd = 0;
    repeat (10) begin
      @(negedge clk);
      if (dn[0][0] || dn[0][1]) nd++;
    end
    chk("reset_no_done", 64'(nd), 64'd0);
    run1(0, 1, 1'b0, 64'd12, 64'd0, 64'd12, "post_reset_load");

    repeat (3) @(negedge clk);
    chk("sb_empty_a", 64'(sbq[0].size()), 64'd0);
    chk("sb_empty_b", 64'(sbq[1].size()), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
